// File: rtl/cmd_frame_ctrl.sv
// cmd_frame_ctrl: framed command receiver and reply generator.
// Reads bytes from a comm receive FIFO and looks for frames of the form
// EB 90 CMD P0 P1 P2 P3 CHK. It runs valid commands, which drive the
// CPU-switch control outputs, and sends a 4-byte reply to the CPU
// transmit FIFOs.
//
// Ports
//   clk           : single clock, rising edge
//   rst_n         : asynchronous active-low reset
//   com_count     : number of bytes held in the selected receive FIFO
//   rec_command   : head byte of the receive FIFO
//   com_pop       : one-cycle pulse that removes the FIFO head byte
//   switch        : currently active CPU (0 = A, 1 = B)
//   force_swi     : commanded-switch mode enable
//   com_swi       : commanded CPU (0 = A, 1 = B)
//   error         : last frame was invalid
//   tdr_cpuAB     : reply byte, 0x00 whenever no push is in progress
//   tf_push_cpuAB : push strobe for tdr_cpuAB
module cmd_frame_ctrl #(
   parameter int          CNT_W       = 5,
   parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] com_count,
   input  logic [7:0]       rec_command,
   output logic             com_pop,
   input  logic             switch,
   output logic             force_swi,
   output logic             com_swi,
   output logic             error,
   output logic [7:0]       tdr_cpuAB,
   output logic             tf_push_cpuAB
);

   localparam logic [15:0] TMO_LAST = TIMEOUT_CYC - 16'd1;

   typedef enum logic [2:0] {HUNT0, HUNT1, BODY, EXEC, REPLY} state_t;

   state_t      state, state_nxt;
   logic [2:0]  idx;
   logic [7:0]  body [0:5];     // CMD, P0..P3, CHK
   logic [15:0] tmo_cnt;
   logic        pop_pending;
   logic [1:0]  reply_cnt;

   logic        in_frame;
   logic        consume;
   logic        timeout;
   logic        frame_ok;
   logic [7:0]  sum;

   assign in_frame = (state == HUNT1) || (state == BODY);

   // The FIFO head may only be read again once the previous pop has taken
   // effect. com_pop covers the cycle after a consume and pop_pending covers
   // the cycle after that, so consumes are spaced at least 3 cycles apart.
   assign consume = ((state == HUNT0) || in_frame) && (com_count != '0)
                    && !com_pop && !pop_pending;

   assign timeout  = in_frame && !consume && (tmo_cnt == TMO_LAST);
   assign sum      = body[0] + body[1] + body[2] + body[3] + body[4];
   assign frame_ok = (sum == body[5]) && (body[0] >= 8'h01) && (body[0] <= 8'h04);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= HUNT0;
      else        state <= state_nxt;
   end

   // The reply outputs come straight from the state. That way an
   // asynchronous reset stops a push in the same instant, and STATUS sees
   // switch in the cycle the byte is pushed.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      state_nxt     = state;
      tf_push_cpuAB = 1'b0;
      tdr_cpuAB     = 8'h00;
      case (state)
         HUNT0: if (consume && rec_command == 8'hEB) state_nxt = HUNT1;
         HUNT1: begin
            if (consume) begin
               if (rec_command == 8'h90)      state_nxt = BODY;
               else if (rec_command != 8'hEB) state_nxt = HUNT0;
            end else if (timeout) begin
               state_nxt = HUNT0;
            end
         end
         BODY: begin
            if (consume && idx == 3'd5) state_nxt = EXEC;
            else if (timeout)           state_nxt = HUNT0;
         end
         EXEC: state_nxt = frame_ok ? REPLY : HUNT0;
         REPLY: begin
            tf_push_cpuAB = 1'b1;
            case (reply_cnt)
               2'd0: tdr_cpuAB = 8'hEB;
               2'd1: tdr_cpuAB = 8'h90;
               2'd2: tdr_cpuAB = body[0];
               default: tdr_cpuAB = {5'b0, error, force_swi, switch};
            endcase
            if (reply_cnt == 2'd3) state_nxt = HUNT0;
         end
         default: state_nxt = HUNT0;
      endcase
   end

   // NOTE: the payload buffer has no reset. It is always written before EXEC reads it, so resetting it would add fan-out and change nothing.
   always_ff @(posedge clk) begin
      if (state == BODY && consume) body[idx] <= rec_command;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples its inputs from before the edge.
         com_pop     <= 1'b0;
         pop_pending <= 1'b0;
         idx         <= 3'd0;
         tmo_cnt     <= 16'd0;
         reply_cnt   <= 2'd0;
         force_swi   <= 1'b0;
         com_swi     <= 1'b0;
         error       <= 1'b0;
      end else begin
         com_pop     <= consume;
         pop_pending <= com_pop;

         if (state != BODY)            idx <= 3'd0;
         else if (consume)             idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;

         // The counter only runs while a frame is partly received. It
         // restarts on every byte and returns to 0 when the timeout fires.
         if (in_frame && !consume && !timeout) tmo_cnt <= tmo_cnt + 16'd1;
         else                                  tmo_cnt <= 16'd0;

         reply_cnt <= (state == REPLY) ? reply_cnt + 2'd1 : 2'd0;

         if (state == EXEC) begin
            if (frame_ok) begin
               error <= 1'b0;
               case (body[0])
                  8'h01: begin force_swi <= 1'b1; com_swi <= 1'b0; end
                  8'h02: begin force_swi <= 1'b1; com_swi <= 1'b1; end
                  8'h03: force_swi <= 1'b0;
                  default: ;
               endcase
            end else begin
               error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/cmd_frame_ctrl.md
CMD_FRAME_CTRL -- requirements
Module: cmd_frame_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 5, the width of the command-byte count input.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16'd50000, the inter-byte timeout in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port com_count, input, CNT_W bits: number of bytes held in the selected comm receive FIFO.
REQ-006 SHALL have port rec_command, input, 8 bits: head byte of the comm receive FIFO.
REQ-007 SHALL have port com_pop, output, 1 bit: one-cycle pulse that removes the FIFO head byte.
REQ-008 SHALL have port switch, input, 1 bit: current active CPU (0 = A, 1 = B).
REQ-009 SHALL have port force_swi, output, 1 bit: commanded-switch mode enable.
REQ-010 SHALL have port com_swi, output, 1 bit: commanded CPU (0 = A, 1 = B).
REQ-011 SHALL have port error, output, 1 bit: last frame invalid.
REQ-012 SHALL have port tdr_cpuAB, output, 8 bits: reply byte to the CPU transmit FIFOs.
REQ-013 SHALL have port tf_push_cpuAB, output, 1 bit: one-cycle push strobe for tdr_cpuAB.

Function
REQ-014 SHALL use this frame format: 8 bytes -- 0xEB, 0x90, CMD, P0, P1, P2, P3, CHK -- where CHK = (CMD+P0+P1+P2+P3) mod 256.
REQ-015 SHALL implement FSM states HUNT0, HUNT1, BODY, EXEC and REPLY; the reset state is HUNT0.
REQ-016 Byte consume SHALL work as follows:
- A byte is consumed in cycle t only if state is HUNT0, HUNT1 or BODY, com_count != 0, and no pop is pending.
- rec_command is sampled at t.
- com_pop is high during t+1 only.
- The next consume is allowed no earlier than t+3.
REQ-017 In HUNT0, a byte of 0xEB SHALL go to HUNT1; any other byte SHALL stay in HUNT0 (discarded).
REQ-018 In HUNT1, 0x90 SHALL go to BODY; 0xEB SHALL stay in HUNT1; any other byte SHALL go to HUNT0.
REQ-019 BODY SHALL store 6 bytes (CMD..CHK) with a 3-bit index, then go to EXEC.
REQ-020 EXEC SHALL last one cycle; a frame is valid iff the checksum matches and CMD is in {0x01, 0x02, 0x03, 0x04}.
REQ-021 On a valid frame, EXEC SHALL apply the command, clear error, and go to REPLY:
- 0x01: force_swi=1, com_swi=0.
- 0x02: force_swi=1, com_swi=1.
- 0x03: force_swi=0, com_swi unchanged.
- 0x04: no change.
REQ-022 On an invalid frame, EXEC SHALL set error=1, leave force_swi/com_swi unchanged, and go to HUNT0 with no reply.
REQ-023 REPLY SHALL push 4 bytes on consecutive cycles (tf_push_cpuAB high for exactly 4 cycles): 0xEB, 0x90, CMD, STATUS.
REQ-024 STATUS SHALL be {5'b0, error, force_swi, switch}, sampled in the cycle it is pushed; after the 4th push the FSM goes to HUNT0.
REQ-025 No com_pop SHALL occur in EXEC or REPLY.
REQ-026 Inter-byte timeout:
- In HUNT1 or BODY, a 16-bit counter increments each cycle without a consume and clears on a consume.
- On reaching TIMEOUT_CYC-1, the FSM goes to HUNT0; the partial frame is discarded; error is unchanged.
- In other states the counter is held at 0.
REQ-027 A com_count drop to 0 mid-frame SHALL not abort the frame; only the timeout aborts it.
REQ-028 tdr_cpuAB SHALL be 0x00 whenever tf_push_cpuAB is low.

Reset
REQ-029 On rst_n low, asynchronously:
- State = HUNT0; index, timeout counter and pop-pending flag = 0.
- com_pop=0, force_swi=0, com_swi=0, error=0, tf_push_cpuAB=0, tdr_cpuAB=0x00.
REQ-030 Reset asserted mid-frame or mid-reply SHALL abandon it; after release, the next consumed byte is treated as HUNT0 input.

Verification
REQ-031 Bytes EB 90 02 00 00 00 00 02 with switch tied to com_swi -> force_swi=1, com_swi=1, 8 com_pop pulses each ≥3 cycles apart, reply EB 90 02 03.
REQ-032 Then EB 90 03 00 00 00 00 03 -> force_swi=0, com_swi stays 1, reply EB 90 03 01 (switch=1).
REQ-033 EB 90 01 00 00 00 00 05 (bad CHK) -> error=1, no push, force/com_swi unchanged; then a valid 0x04 frame -> error=0, reply STATUS bit2=0.
REQ-034 Prefix garbage 12 EB EB 90 then 01 00 00 00 00 01 -> 0x12 discarded, frame accepted, force_swi=1, com_swi=0.
REQ-035 EB 90 01 then no bytes for TIMEOUT_CYC cycles -> back to HUNT0, no push, error=0; following bytes 00 00 00 00 01 are discarded.
REQ-036 rst_n pulsed low during the 2nd reply push -> push stops immediately, all outputs 0, FSM in HUNT0.
